unsigned_multiplier: RTL and testbench
======================================

# unsigned_multiplier

Fully pipelined unsigned integer multiplier: every clock it accepts one operand pair `a`, `b` and, a fixed number of cycles later, presents the full-width product on `q`. It has no handshake and sustains a throughput of one product per cycle. It serves as a generic arithmetic primitive inside datapaths that tolerate fixed latency.

## Interface
- `BITWIDTH_INPUT`, default 32: operand width N (N ≥ 1).
- `LATENCY` (localparam, not overridable): 2 + ceil(log2(N)). Equals 7 for N = 32.

Ports:
- `clk`  input  1  sole clock; all registers are rising-edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `a`  input  N  multiplicand, unsigned.
- `b`  input  N  multiplier, unsigned.
- `q`  output  2N  product a × b, unsigned, registered.

## Operation
- Stage 0 (input register): capture `a` and `b` on every rising edge while `rstn` = 1.
- Stage 1 (partial products): pp[i] = (b_reg[i] ? a_reg : 0) << i, for i = 0..N-1.
  - Each pp[i] is zero-extended to 2N bits and registered.
- Stages 2 to LATENCY-1 (adder tree):
  - Each level adds adjacent pairs of the previous level's terms, modulo 2^2N. No overflow is possible because a full product fits in 2N bits.
  - With an odd term count, the last term passes through that level's register unchanged.
  - The tree has ceil(log2 N) levels. For N = 1 the tree is empty and pp[0] drives the output register directly.
- The final level's single term is `q`. No extra register follows it.
- No valid/ready signals:
  - A new pair is consumed every cycle, whether or not it changed.
  - A constant input yields a constant `q` once the pipeline has filled.
- Output is purely unsigned. Operands are never sign-interpreted.

## Timing
- Pair sampled at rising edge k appears on `q` immediately after rising edge k + LATENCY - 1. In other words, it is visible LATENCY edges after the inputs were set up, counting the capture edge as the first.
- For N = 32, inputs applied mid-cycle before edge k are visible on `q` after edge k+6 (7 edges inclusive).
- Reset, asserted at any time:
  - Every pipeline register and `q` clear to 0 immediately, without waiting for a clock edge.
  - Reset mid-stream discards all in-flight products. None reappear after release.
- After `rstn` deasserts, `q` stays 0 until the first pair sampled after release emerges LATENCY edges later.
- Inputs sampled while `rstn` = 0 are ignored.
- Back-to-back distinct pairs produce back-to-back distinct products, in order, with no bubbles.

## Structure
- Shared package `multiplier_pkg`:
  - function `mul_latency(n)`, returning 2 + $clog2(n), used for the localparam and by benches;
  - helper `clog2` for tree depth where the tool lacks `$clog2` in constant contexts.
- One natural sub-module, `adder_tree_level`:
  - parameters: term count M and width W;
  - behaviour: a registered pairwise-add stage with the odd-term pass-through and its own async active-low reset;
  - the top instantiates one per tree level in a generate loop.

## Test plan
- Reset: hold `rstn` = 0 for 50 cycles with a = 0xFFFFFFFF, b = 0xFFFFFFFF. Required: `q` = 0 throughout, and for LATENCY-1 cycles after release.
- Sweep: after release, step a = 0..15 and, for each a, step b = 0..15, one new pair per cycle. Required: `q` = a×b exactly LATENCY-1 cycles after each pair is applied (for example a = 15, b = 15 gives 225), with no missed or duplicated values.
- Extremes: a = b = 0xFFFFFFFF gives 0xFFFFFFFE00000001. a = 0xFFFFFFFF, b = 1 gives 0x00000000FFFFFFFF. a = 0x80000000, b = 2 gives 0x0000000100000000. a = 0, b = 0xFFFFFFFF gives 0.
- Reset mid-stream: pulse `rstn` low for 2 cycles during the sweep. Required:
  - `q` goes 0 asynchronously within the same cycle;
  - it stays 0 until the first post-release pair emerges;
  - no pre-reset products appear.
- Parameter variants:
  - N = 8 (LATENCY 5): 255 × 255 = 0xFE01;
  - N = 1 (LATENCY 2): 1 × 1 = 1;
  - N = 5 (odd tree, LATENCY 5): 31 × 31 = 961.
- Random: 10,000 random back-to-back pairs at N = 32, compared against a reference model delayed by LATENCY-1 cycles. Required: zero mismatches.

Source files
------------

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: latency and adder-tree geometry helpers shared by the multiplier and its benches.
package multiplier_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int mul_latency(input int n);
    return 2 + $clog2(n);
  endfunction
  // Term count entering tree level l: each level halves, rounding up for the odd pass-through.
  function automatic int tree_terms(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction
  function automatic int tree_offset(input int n, input int l, input int w);
    int o;
    o = 0;
    for (int i = 0; i < l; i++) o += tree_terms(n, i) * w;
    return o;
  endfunction
endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: registered pairwise add of M W-bit terms; an odd last term passes through.
module adder_tree_level #(
  parameter int M = 2,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [M*W-1:0]           d,
  output logic [((M+1)/2)*W-1:0]   q
);
  localparam int O = (M + 1) / 2;
  localparam int DW = 2 * O * W;
  logic [DW-1:0] dx;
  logic [O*W-1:0] nxt;
  // Zero-padding to an even count turns the odd pass-through into an add with zero.
  assign dx = DW'(d);
  always_comb begin
    nxt = '0;
    for (int i = 0; i < O; i++) nxt[i*W +: W] = dx[2*i*W +: W] + dx[(2*i+1)*W +: W];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/unsigned_multiplier.sv
// unsigned_multiplier: fully pipelined N x N -> 2N unsigned multiplier, one product per cycle,
// latency 2 + ceil(log2 N): input register, partial-product register, then a registered adder tree.
module unsigned_multiplier import multiplier_pkg::*; #(
  parameter int BITWIDTH_INPUT = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [BITWIDTH_INPUT-1:0]     a,
  input  logic [BITWIDTH_INPUT-1:0]     b,
  output logic [2*BITWIDTH_INPUT-1:0]   q
);
  localparam int N = BITWIDTH_INPUT;
  localparam int W = 2 * N;
  localparam int LATENCY = mul_latency(N);
  localparam int DEPTH = LATENCY - 2;
  localparam int TOTAL = tree_offset(N, DEPTH + 1, W);
  logic [N-1:0] a_r, b_r;
  logic [N*W-1:0] pp;
  wire [TOTAL-1:0] bus;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pp <= '0;
    else for (int i = 0; i < N; i++) pp[i*W +: W] <= b_r[i] ? (W'(a_r) << i) : '0;
  // bus holds every level back to back: pp terms first, the single final sum last.
  assign bus[N*W-1:0] = pp;
  for (genvar l = 0; l < DEPTH; l++) begin : g_tree
    localparam int M = tree_terms(N, l);
    adder_tree_level #(.M(M), .W(W)) u_level (
      .clk  (clk),
      .rstn (rstn),
      .d    (bus[tree_offset(N, l, W) +: M*W]),
      .q    (bus[tree_offset(N, l + 1, W) +: ((M+1)/2)*W])
    );
  end
  assign q = bus[tree_offset(N, DEPTH, W) +: W];
endmodule

// File: tb/tb_unsigned_multiplier.sv
// tb_unsigned_multiplier: scoreboard bench; the driver queues expected products, a monitor pops them when due.
module tb_unsigned_multiplier;
  localparam int LAT = 7;
  typedef struct { logic [63:0] val; int due; } item_t;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] q;
  logic [7:0] a8 = 8'hFF, b8 = 8'hFF;
  logic [15:0] q8;
  logic a1 = 1'b1, b1 = 1'b1;
  logic [1:0] q1;
  logic [4:0] a5 = 5'd31, b5 = 5'd31;
  logic [9:0] q5;
  item_t sb[$];
  item_t m;
  int cyc = 0, n_vec = 0, n_err = 0;

  unsigned_multiplier #(.BITWIDTH_INPUT(32)) dut (.clk(clk), .rstn(rstn), .a(a), .b(b), .q(q));
  unsigned_multiplier #(.BITWIDTH_INPUT(8)) u8 (.clk(clk), .rstn(rstn), .a(a8), .b(b8), .q(q8));
  unsigned_multiplier #(.BITWIDTH_INPUT(1)) u1 (.clk(clk), .rstn(rstn), .a(a1), .b(b1), .q(q1));
  unsigned_multiplier #(.BITWIDTH_INPUT(5)) u5 (.clk(clk), .rstn(rstn), .a(a5), .b(b5), .q(q5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, want);
    end
  endtask

  always @(negedge clk)
    if (sb.size() != 0 && sb[0].due == cyc) begin
      m = sb.pop_front();
      check("product", q, m.val);
    end

  // r=0 samples this pair under reset; entering reset zeroes every in-flight expectation.
  task automatic drive(input logic [31:0] x, input logic [31:0] y, input bit r, input logic [63:0] e);
    @(negedge clk);
    a = x;
    b = y;
    if (r) rstn = 1'b1;
    sb.push_back('{val: r ? e : 64'd0, due: cyc + LAT});
    if (!r && rstn) begin
      #2 rstn = 1'b0;
      foreach (sb[i]) sb[i].val = '0;
      #1 check("async_clear", q, 64'd0);
    end
  endtask

  initial begin
    repeat (50) begin
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd0);
      check("reset_q", q, 64'd0);
      check("reset_q8", 64'(q8), 64'd0);
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        if (i == 8 && j == 0) repeat (2) drive(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 64'd0);
        drive(32'(i), 32'(j), 1'b1, 64'(i * j));
      end
    drive(32'd15, 32'd15, 1'b1, 64'd225);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'h0000_0000_FFFF_FFFF);
    drive(32'h8000_0000, 32'h0000_0002, 1'b1, 64'h0000_0001_0000_0000);
    drive(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'd0);
    drive(32'h0001_0000, 32'h0001_0000, 1'b1, 64'h0000_0001_0000_0000);
    for (int k = 0; k < 10000; k++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = $urandom;
      drive(x, y, 1'b1, {32'd0, x} * {32'd0, y});
    end
    repeat (LAT + 2) @(negedge clk);
    check("drained", 64'(sb.size()), 64'd0);
    check("n8_product", 64'(q8), 64'h0000_0000_0000_FE01);
    check("n1_product", 64'(q1), 64'd1);
    check("n5_product", 64'(q5), 64'd961);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
